amber_wb_responder: RTL
=======================

AMBER_WB_RESPONDER -- requirements
Module: amber_wb_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 128-bit memory words (power of 2, 16..4096).
REQ-002 Parameter WAIT_STATES, default 1, extra cycles inserted before each response (0..7).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address of memory word 0 (16-byte aligned).
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_wb_adr, input, 32: byte address from core.
REQ-007 Port i_wb_sel, input, 16: byte-lane enables; bit i selects byte [8i+7:8i].
REQ-008 Port i_wb_we, input, 1: 1 = write, 0 = read.
REQ-009 Port i_wb_dat, input, 128: write data from core.
REQ-010 Port i_wb_cyc, input, 1: bus cycle active.
REQ-011 Port i_wb_stb, input, 1: request strobe.
REQ-012 Port o_wb_dat, output, 128: read data to core.
REQ-013 Port o_wb_ack, output, 1: successful completion, one-cycle pulse.
REQ-014 Port o_wb_err, output, 1: error completion, one-cycle pulse.
REQ-015 Port i_ld_valid, input, 1: testbench preload strobe.
REQ-016 Port i_ld_addr, input, log2(MEM_WORDS): preload word index.
REQ-017 Port i_ld_data, input, 128: preload data (all 16 bytes written).
REQ-018 Port o_rd_count, output, 16: completed read acks.
REQ-019 Port o_wr_count, output, 16: completed write acks.

Function
REQ-020 FSM states: IDLE, WAIT, RESP.
REQ-021 IDLE: on i_wb_cyc & i_wb_stb, latch adr/we/sel/dat; go to WAIT if WAIT_STATES>0, else RESP.
REQ-022 WAIT: count down WAIT_STATES cycles, then go to RESP.
REQ-023 Response latency: request sampled in cycle N; o_wb_ack or o_wb_err high in exactly cycle N+1+WAIT_STATES, for one cycle only.
REQ-024 RESP: assert completion for one cycle, then return to IDLE; the next request is accepted no earlier than the cycle after RESP.
REQ-025 In range: BASE_ADDR <= adr and (adr - BASE_ADDR) < MEM_WORDS*16; word index = (adr - BASE_ADDR) >> 4; adr[3:0] is ignored.
REQ-026 In-range read: o_wb_ack=1 and o_wb_dat = memory word, with lanes whose sel bit is 0 driven to 0.
REQ-027 In-range write: in the RESP cycle, write only the bytes whose sel bit is 1; o_wb_ack=1.
REQ-028 Out-of-range access: o_wb_err=1, o_wb_ack=0, no memory write, o_wb_dat=0, counters unchanged.
REQ-029 o_wb_dat = 0 in every cycle without an ack.
REQ-030 o_wb_ack and o_wb_err are never high in the same cycle.
REQ-031 Abort: i_wb_cyc or i_wb_stb low during WAIT or RESP -> return to IDLE next cycle with no write, no ack/err, no count.
REQ-032 Preload: i_ld_valid writes i_ld_data to i_ld_addr in any state, in the same cycle.
REQ-033 Preload vs. bus write to the same word in the same cycle: enabled bus lanes take bus data; other lanes take preload data.
REQ-034 Counters: increment on each read/write ack; saturate at 16'hFFFF.

Reset
REQ-035 rst=1 forces the FSM to IDLE, o_wb_ack=0, o_wb_err=0, o_wb_dat=0, and both counters to 0, taking effect at the next clock edge.
REQ-036 Memory contents are not cleared by reset; a preload in a reset cycle is still performed.
REQ-037 rst mid-transaction discards that transaction: no write, no completion.

Verification
REQ-038 Preload word 3 = 128'h0123..CDEF; read adr 32'h30, sel 16'hFFFF, WAIT_STATES=1 -> ack in cycle N+2, o_wb_dat = preload value, o_rd_count=1.
REQ-039 Write adr 32'h40, sel 16'h000F, dat all-ones over word 4 = 0 -> subsequent full read returns 128'h...0000_FFFF_FFFF, o_wr_count=1.
REQ-040 Read adr BASE_ADDR + MEM_WORDS*16 (32'h1000) -> o_wb_err one cycle, o_wb_ack=0, o_wb_dat=0, counters unchanged.
REQ-041 Drop i_wb_stb during WAIT with WAIT_STATES=3 on a write -> no ack/err, memory unchanged, FSM back in IDLE.
REQ-042 Assert rst during WAIT -> no completion; counters read 0; preloaded data still readable afterwards.
REQ-043 Back-to-back reads with WAIT_STATES=0 and stb held -> one ack every 2 cycles, never two consecutive ack cycles.

Source files
------------

// File: rtl/amber_wb_responder.sv
// rtl/amber_wb_responder.sv - 128-bit Wishbone memory responder with wait states, preload port and ack counters
module amber_wb_responder #(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  i_wb_adr,
    input  logic [15:0]                  i_wb_sel,
    input  logic                         i_wb_we,
    input  logic [127:0]                 i_wb_dat,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    output logic [127:0]                 o_wb_dat,
    output logic                         o_wb_ack,
    output logic                         o_wb_err,
    input  logic                         i_ld_valid,
    input  logic [$clog2(MEM_WORDS)-1:0] i_ld_addr,
    input  logic [127:0]                 i_ld_data,
    output logic [15:0]                  o_rd_count,
    output logic [15:0]                  o_wr_count
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN     = 32'(MEM_WORDS * 16);
    localparam logic [2:0]  CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      wait_cnt;
    logic [31:0]     lat_adr;
    logic [15:0]     lat_sel;
    logic            lat_we;
    logic [127:0]    lat_dat;
    logic [127:0]    mem [MEM_WORDS];

    logic            req;
    logic [31:0]     offset;
    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic            resp_live;
    logic            do_write;

    assign req       = i_wb_cyc & i_wb_stb;
    assign offset    = lat_adr - BASE_ADDR;
    assign in_range  = (lat_adr >= BASE_ADDR) && (offset < SPAN);
    assign word_idx  = offset[AW+3:4];
    // A completion only happens if the master still holds the request and no reset is pending
    assign resp_live = (state == S_RESP) && req && !rst;
    assign do_write  = resp_live && in_range && lat_we;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept, count down wait states, respond, abort on dropped request
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == 3'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: ack with lane-masked read data, or err for out-of-range; data is zero otherwise
    always_comb begin
        o_wb_ack = 1'b0;
        o_wb_err = 1'b0;
        o_wb_dat = '0;
        if (resp_live) begin
            if (in_range) begin
                o_wb_ack = 1'b1;
                if (!lat_we) begin
                    for (int i = 0; i < 16; i++) begin
                        o_wb_dat[8*i +: 8] = lat_sel[i] ? mem[word_idx][8*i +: 8] : 8'h00;
                    end
                end
            end else begin
                o_wb_err = 1'b1;
            end
        end
    end

    // Request latch and wait-state counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 3'd0;
            lat_adr  <= '0;
            lat_sel  <= '0;
            lat_we   <= 1'b0;
            lat_dat  <= '0;
        end else if (state == S_IDLE && req) begin
            wait_cnt <= CNT_INIT;
            lat_adr  <= i_wb_adr;
            lat_sel  <= i_wb_sel;
            lat_we   <= i_wb_we;
            lat_dat  <= i_wb_dat;
        end else if (state == S_WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Memory: preload first, then enabled bus lanes override it when both hit the same word
    always_ff @(posedge clk) begin
        if (i_ld_valid) begin
            mem[i_ld_addr] <= i_ld_data;
        end
        if (do_write) begin
            for (int i = 0; i < 16; i++) begin
                if (lat_sel[i]) begin
                    mem[word_idx][8*i +: 8] <= lat_dat[8*i +: 8];
                end
            end
        end
    end

    // Saturating completion counters
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd_count <= 16'd0;
            o_wr_count <= 16'd0;
        end else if (o_wb_ack) begin
            if (lat_we) begin
                if (o_wr_count != 16'hFFFF) o_wr_count <= o_wr_count + 16'd1;
            end else begin
                if (o_rd_count != 16'hFFFF) o_rd_count <= o_rd_count + 16'd1;
            end
        end
    end

endmodule
